fib_req_arb: RTL and testbench

FIB_REQ_ARB -- requirements
Module: fib_req_arb

---
 rtl/fib_req_arb.sv | 161 ++++++++++++++++
 tb/tb_fib_req_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_req_arb.sv
// Two-requester round-robin arbiter in front of a shared BCD Fibonacci engine.
// Captures one operand per grant, drives the engine, and returns the result to its owner.
module fib_req_arb #(
  parameter int TMO_CYC = 1023
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic        iREQ0,
  input  logic        iREQ1,
  input  logic [15:0] iBCD_A0,
  input  logic [15:0] iBCD_A1,
  output logic        oGNT0,
  output logic        oGNT1,
  output logic        oVLD0,
  output logic        oVLD1,
  output logic [15:0] oBCD_R0,
  output logic [15:0] oBCD_R1,
  output logic        oOFLOW0,
  output logic        oOFLOW1,
  output logic        oENG_START,
  output logic [15:0] oENG_BCD,
  input  logic        iENG_READY,
  input  logic        iENG_DONE,
  input  logic        iENG_OFLOW,
  input  logic [15:0] iENG_BCD,
  output logic        oBUSY,
  output logic        oERR
);

  localparam int CW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_st;
  logic          r_own;
  logic          r_ptr;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_opnd;
  logic [15:0]   r_res;
  logic          r_res_of;
  logic          r_gnt0, r_gnt1;
  logic          r_vld0, r_vld1;
  logic [15:0]   r_bcd_r0, r_bcd_r1;
  logic          r_of0, r_of1;
  logic          r_start;
  logic          r_busy;
  logic          r_err;

  logic          w_pick;
  logic          w_bad;
  logic          w_tmo;

  // Both asking: the pointer decides; otherwise the lone requester wins.
  assign w_pick = (iREQ0 && iREQ1) ? r_ptr : iREQ1;

  assign w_bad = (r_opnd[3:0]   > 4'd9) || (r_opnd[7:4]   > 4'd9) ||
                 (r_opnd[11:8]  > 4'd9) || (r_opnd[15:12] > 4'd9);

  assign w_tmo = (r_cnt == CW'(TMO_CYC - 1));

  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      r_st     <= S_IDLE;
      r_own    <= 1'b0;
      r_ptr    <= 1'b0;
      r_cnt    <= '0;
      r_opnd   <= 16'h0000;
      r_res    <= 16'h0000;
      r_res_of <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_vld0   <= 1'b0;
      r_vld1   <= 1'b0;
      r_bcd_r0 <= 16'h0000;
      r_bcd_r1 <= 16'h0000;
      r_of0    <= 1'b0;
      r_of1    <= 1'b0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_start <= 1'b0;
      unique case (r_st)
        S_IDLE: begin
          if (iREQ0 || iREQ1) begin
            r_own  <= w_pick;
            r_gnt0 <= ~w_pick;
            r_gnt1 <= w_pick;
            r_opnd <= w_pick ? iBCD_A1 : iBCD_A0;
            r_busy <= 1'b1;
            r_st   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_bad) begin
            r_res    <= 16'h0000;
            r_res_of <= 1'b1;
            r_st     <= S_RESP;
          end else if (iENG_READY) begin
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_st    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (iENG_DONE) begin
            r_res    <= iENG_BCD;
            r_res_of <= iENG_OFLOW;
            r_st     <= S_RESP;
          end else if (w_tmo) begin
            r_res    <= 16'h0000;
            r_res_of <= 1'b1;
            r_err    <= 1'b1;
            r_st     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (r_own) begin
            r_bcd_r1 <= r_res;
            r_of1    <= r_res_of;
            r_vld1   <= 1'b1;
          end else begin
            r_bcd_r0 <= r_res;
            r_of0    <= r_res_of;
            r_vld0   <= 1'b1;
          end
          r_ptr  <= ~r_own;
          r_busy <= 1'b0;
          r_st   <= S_IDLE;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign oGNT0      = r_gnt0;
  assign oGNT1      = r_gnt1;
  assign oVLD0      = r_vld0;
  assign oVLD1      = r_vld1;
  assign oBCD_R0    = r_bcd_r0;
  assign oBCD_R1    = r_bcd_r1;
  assign oOFLOW0    = r_of0;
  assign oOFLOW1    = r_of1;
  assign oENG_START = r_start;
  assign oENG_BCD   = r_opnd;
  assign oBUSY      = r_busy;
  assign oERR       = r_err;

endmodule

// File: tb/tb_fib_req_arb.sv
// Directed bench for fib_req_arb with a behavioural Fibonacci engine.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_fib_req_arb;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] a0, a1;
  logic        gnt0, gnt1, vld0, vld1;
  logic [15:0] r0, r1;
  logic        of0, of1;
  logic        eng_start;
  logic [15:0] eng_op_out;
  logic        eng_ready, eng_done, eng_of;
  logic [15:0] eng_res;
  logic        busy, err;

  int n_vec = 0;
  int n_err = 0;

  int          eng_cnt   = 0;
  int          eng_lat   = 12;
  bit          eng_hang  = 1'b0;
  int          eng_fires = 0;
  logic [15:0] eng_op    = 16'h0000;

  fib_req_arb #(.TMO_CYC(TMO)) dut (
    .iCLK       (clk),
    .iRESET_N   (rst_n),
    .iREQ0      (req0),
    .iREQ1      (req1),
    .iBCD_A0    (a0),
    .iBCD_A1    (a1),
    .oGNT0      (gnt0),
    .oGNT1      (gnt1),
    .oVLD0      (vld0),
    .oVLD1      (vld1),
    .oBCD_R0    (r0),
    .oBCD_R1    (r1),
    .oOFLOW0    (of0),
    .oOFLOW1    (of1),
    .oENG_START (eng_start),
    .oENG_BCD   (eng_op_out),
    .iENG_READY (eng_ready),
    .iENG_DONE  (eng_done),
    .iENG_OFLOW (eng_of),
    .iENG_BCD   (eng_res),
    .oBUSY      (busy),
    .oERR       (err)
  );

  always #5 clk = ~clk;

  // Engine: done pulse eng_lat cycles after the start cycle, table-driven result.
  always @(negedge clk) begin
    eng_done = 1'b0;
    eng_of   = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0 && !eng_hang) begin
        eng_done  = 1'b1;
        eng_fires = eng_fires + 1;
        case (eng_op)
          16'h0007: eng_res = 16'h0013;
          16'h0010: eng_res = 16'h0055;
          16'h0012: eng_res = 16'h0144;
          16'h0020: eng_res = 16'h6765;
          16'h0030: begin eng_res = 16'h0000; eng_of = 1'b1; end
          default:  eng_res = 16'h9999;
        endcase
      end
    end
    if (eng_start) begin
      eng_cnt = eng_lat;
      eng_op  = eng_op_out;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    eng_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a0 = 16'h0000;
    a1 = 16'h0000;
    eng_res = 16'h0000;
    do_reset();
    n_vec++;
    if ({gnt0, gnt1, vld0, vld1, eng_start, busy, err, of0, of1} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000000000",
               {gnt0, gnt1, vld0, vld1, eng_start, busy, err, of0, of1});
    end
    n_vec++;
    if ({r0, r1, eng_op_out} !== 48'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h/%h/%h want 0000/0000/0000", r0, r1, eng_op_out);
    end
  endtask

  task automatic test_single();
    int ng = 0, ns = 0, nv = 0, oth = 0, ts = 0, tv = 0;
    eng_lat = 12;
    a0 = 16'h0010;
    req0 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (gnt0) begin ng++; req0 = 1'b0; end
      if (eng_start) begin ns++; ts = c; end
      if (vld0) begin nv++; tv = c; end
      if (gnt1 || vld1) oth++;
    end
    n_vec++;
    if (ng != 1 || ns != 1 || nv != 1) begin
      n_err++;
      $display("FAIL single_counts: got gnt=%0d start=%0d vld=%0d want 1/1/1", ng, ns, nv);
    end
    n_vec++;
    if (tv - ts != 14) begin
      n_err++;
      $display("FAIL single_latency: got %0d want 14", tv - ts);
    end
    n_vec++;
    if (r0 !== 16'h0055 || of0 !== 1'b0) begin
      n_err++;
      $display("FAIL single_result: got %h/%b want 0055/0", r0, of0);
    end
    n_vec++;
    if (oth != 0 || r1 !== 16'h0000 || of1 !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_quiet: got oth=%0d r1=%h of1=%b busy=%b want 0/0000/0/0",
               oth, r1, of1, busy);
    end
  endtask

  task automatic test_bad_operand();
    int ns = 0, nv = 0, tg = 0, tv = -100;
    a1 = 16'h00A3;
    req1 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt1) begin tg = c; req1 = 1'b0; end
      if (eng_start) ns++;
      if (vld1) begin nv++; tv = c; end
    end
    n_vec++;
    if (ns != 0 || nv != 1) begin
      n_err++;
      $display("FAIL bad_counts: got start=%0d vld1=%0d want 0/1", ns, nv);
    end
    n_vec++;
    if (tv - tg != 2) begin
      n_err++;
      $display("FAIL bad_latency: got %0d want 2", tv - tg);
    end
    n_vec++;
    if (r1 !== 16'h0000 || of1 !== 1'b1) begin
      n_err++;
      $display("FAIL bad_result: got %h/%b want 0000/1", r1, of1);
    end
  endtask

  task automatic test_ready_low();
    int ns = 0, ng = 0, nv = 0;
    eng_ready = 1'b0;
    a0 = 16'h0020;
    req0 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt0) begin ng++; req0 = 1'b0; end
      if (eng_start) ns++;
    end
    n_vec++;
    if (ns != 0 || ng != 1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL ready_hold: got start=%0d gnt=%0d busy=%b want 0/1/1", ns, ng, busy);
    end
    eng_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (eng_start) ns++;
      if (vld0) nv++;
    end
    n_vec++;
    if (ns != 1 || nv != 1 || r0 !== 16'h6765) begin
      n_err++;
      $display("FAIL ready_go: got start=%0d vld=%0d r0=%h want 1/1/6765", ns, nv, r0);
    end
  endtask

  task automatic test_round_robin();
    int ng = 0, nv0 = 0, nv1 = 0, dbl = 0;
    do_reset();
    eng_lat = 12;
    a0 = 16'h0007;
    a1 = 16'h0030;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if ((gnt0 && gnt1) || (vld0 && vld1)) dbl++;
      if (gnt0 || gnt1) begin
        n_vec++;
        if (gnt1 !== ng[0]) begin
          n_err++;
          $display("FAIL rr_grant%0d: got gnt1=%b want %b", ng, gnt1, ng[0]);
        end
        ng++;
        if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (vld0) begin
        nv0++;
        n_vec++;
        if (r0 !== 16'h0013 || of0 !== 1'b0) begin
          n_err++;
          $display("FAIL rr_res0: got %h/%b want 0013/0", r0, of0);
        end
      end
      if (vld1) begin
        nv1++;
        n_vec++;
        if (r1 !== 16'h0000 || of1 !== 1'b1) begin
          n_err++;
          $display("FAIL rr_res1: got %h/%b want 0000/1", r1, of1);
        end
      end
    end
    n_vec++;
    if (ng != 4 || nv0 != 2 || nv1 != 2 || dbl != 0) begin
      n_err++;
      $display("FAIL rr_counts: got gnt=%0d v0=%0d v1=%0d dbl=%0d want 4/2/2/0",
               ng, nv0, nv1, dbl);
    end
  endtask

  task automatic test_done_at_timeout();
    int ts = 0, tv = 0, nv = 0;
    do_reset();
    eng_lat = TMO - 1;
    a0 = 16'h0012;
    req0 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (eng_start) ts = c;
      if (vld0) begin nv++; tv = c; end
    end
    n_vec++;
    if (nv != 1 || tv - ts != TMO + 1) begin
      n_err++;
      $display("FAIL tie_timing: got vld=%0d lat=%0d want 1/%0d", nv, tv - ts, TMO + 1);
    end
    n_vec++;
    if (r0 !== 16'h0144 || of0 !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL tie_result: got %h/%b err=%b want 0144/0 err=0", r0, of0, err);
    end
  endtask

  task automatic test_timeout();
    int ts = 0, tv = 0, nv = 0;
    eng_hang = 1'b1;
    eng_lat = 12;
    a0 = 16'h0010;
    req0 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (eng_start) ts = c;
      if (vld0) begin nv++; tv = c; end
    end
    n_vec++;
    if (nv != 1 || tv - ts != TMO + 1) begin
      n_err++;
      $display("FAIL tmo_timing: got vld=%0d lat=%0d want 1/%0d", nv, tv - ts, TMO + 1);
    end
    n_vec++;
    if (r0 !== 16'h0000 || of0 !== 1'b1 || err !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_result: got %h/%b err=%b want 0000/1 err=1", r0, of0, err);
    end
    eng_hang = 1'b0;
    nv = 0;
    a1 = 16'h0007;
    req1 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt1) req1 = 1'b0;
      if (vld1) nv++;
    end
    n_vec++;
    if (nv != 1 || r1 !== 16'h0013 || of1 !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_next: got vld=%0d %h/%b want 1 0013/0", nv, r1, of1);
    end
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_sticky: got err=%b want 1", err);
    end
  endtask

  task automatic test_reset_mid_wait();
    int f0, nv = 0, nb = 0;
    bit started = 1'b0;
    eng_lat = 12;
    a0 = 16'h0010;
    req0 = 1'b1;
    for (int c = 0; c < 20 && !started; c++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (eng_start) started = 1'b1;
    end
    n_vec++;
    if (!started) begin
      n_err++;
      $display("FAIL mid_start: got no start within 20 cycles want 1");
    end
    repeat (3) @(negedge clk);
    f0 = eng_fires;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if ({gnt0, gnt1, vld0, vld1, eng_start, busy, err, of0, of1} !== 9'd0) begin
      n_err++;
      $display("FAIL mid_flags: got %b want 000000000",
               {gnt0, gnt1, vld0, vld1, eng_start, busy, err, of0, of1});
    end
    n_vec++;
    if ({r0, r1, eng_op_out} !== 48'd0) begin
      n_err++;
      $display("FAIL mid_data: got %h/%h/%h want 0000/0000/0000", r0, r1, eng_op_out);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vld0 || vld1) nv++;
      if (busy) nb++;
    end
    n_vec++;
    if (eng_fires - f0 != 1 || nv != 0 || nb != 0 || r0 !== 16'h0000) begin
      n_err++;
      $display("FAIL mid_ignore: got done=%0d vld=%0d busy=%0d r0=%h want 1/0/0/0000",
               eng_fires - f0, nv, nb, r0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_operand();
    test_ready_low();
    test_round_robin();
    test_done_at_timeout();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
